i2f_conv: RTL

- Sequential signed-integer to floating-point converter.
- Produces operands in the same sign/exponent/mantissa format that the floating-point adder consumes, so it sits upstream of the adder on the operand-writing side.
- Normalisation is iterative: one left shift per cycle under a small FSM, with an en/busy/res_val handshake.
- Rounding is truncation toward zero.

---
 rtl/i2f_conv.sv | 104 ++++++++++
 1 files changed

// File: rtl/i2f_conv.sv
// Sequential signed-integer to floating-point converter. It produces {sign, exp, mant}
// operands for the downstream adder, normalising with one left shift per cycle.
module i2f_conv #(
  parameter int N = 32,
  parameter int E = 8,
  parameter int S = 1,
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] op,
  output logic         busy,
  output logic         res_val,
  output logic [N-1:0] res
);

  localparam int M    = N - E - S;
  localparam int BIAS = (1 << (E - 1)) - 1;
  localparam logic [E-1:0] EXP_INIT = E'(BIAS + W - 1);
  localparam logic [E-1:0] EXP_ONE  = E'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    PACK = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           sign_q, sign_d;
  logic [W-1:0]   mag_q, mag_d;
  logic [E-1:0]   exp_q, exp_d;
  logic           res_val_q, res_val_d;
  logic [N-1:0]   res_q, res_d;

  // Next-state, datapath and result computation.
  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    mag_d     = mag_q;
    exp_d     = exp_q;
    res_val_d = 1'b0;
    res_d     = res_q;
    case (state_q)
      IDLE: begin
        if (en) begin
          sign_d  = op[W-1];
          // Negating the most negative value wraps back to 2^(W-1), which is the correct magnitude.
          mag_d   = op[W-1] ? (~op + {{(W-1){1'b0}}, 1'b1}) : op;
          exp_d   = EXP_INIT;
          state_d = NORM;
        end else begin
          state_d = IDLE;
        end
      end
      NORM: begin
        // A zero magnitude leaves after one NORM cycle, so zero takes the same two cycles as a normalised input.
        if (mag_q[W-1] || (mag_q == {W{1'b0}})) begin
          state_d = PACK;
        end else begin
          mag_d   = mag_q << 1;
          exp_d   = exp_q - EXP_ONE;
          state_d = NORM;
        end
      end
      PACK: begin
        res_val_d = 1'b1;
        state_d   = IDLE;
        if (mag_q == {W{1'b0}}) begin
          res_d = {N{1'b0}};
        end else begin
          res_d = {sign_q, exp_q, mag_q[W-2 -: M]};
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sign_q    <= 1'b0;
      mag_q     <= {W{1'b0}};
      exp_q     <= {E{1'b0}};
      res_val_q <= 1'b0;
      res_q     <= {N{1'b0}};
    end else begin
      state_q   <= state_d;
      sign_q    <= sign_d;
      mag_q     <= mag_d;
      exp_q     <= exp_d;
      res_val_q <= res_val_d;
      res_q     <= res_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign res_val = res_val_q;
  assign res     = res_q;

endmodule
